// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
// ----------------------------------------------------------------------------
// Pops WIDTH-bit words from a first-word-fall-through FIFO and sends each one
// on a single serial line as an asynchronous frame:
//   start bit (0), WIDTH data bits LSB first, optional even-parity bit,
//   STOP_BITS stop bits (1). Every bit lasts CLKS_PER_BIT clk cycles.
//
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN
//   defined   -> a PARITY bit (XOR of the loaded word) follows the data bits
//   undefined -> data bits are followed directly by the stop bits
//
// Ports
//   clk            in   system clock, rising edge
//   res_n          in   asynchronous active-low reset
//   enable         in   permits starting new frames
//   fifo_empty     in   FIFO empty flag
//   fifo_data      in   FIFO head word (valid while fifo_empty = 0)
//   fifo_shift_out out  one-cycle pop strobe to the FIFO
//   tx             out  serial line, idle high
//   busy           out  high while a frame is in progress
//
// Handshake: the FIFO offers a word whenever fifo_empty = 0. A word is taken
// at the rising clk edge where fifo_shift_out = 1; fifo_data is captured on
// that same edge and the FIFO advances to its next word on that edge.
// fifo_shift_out is only raised when fifo_empty = 0 and res_n = 1.
//
// The FSM state is visible as the internal signal `state` (type state_t).
// ----------------------------------------------------------------------------
module fifo_serial_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_shift_out,
  output logic             tx,
  output logic             busy
);

  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_MAX = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef FIFO_SERIAL_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [BAUD_W-1:0]  baud;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   shift;
  logic               bit_end;
  logic               last_stop;
  logic               pop;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic               parity_bit;
`endif

  assign bit_end   = (baud == BAUD_LAST);
  assign last_stop = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);

  // Gating with res_n keeps the strobe low while reset holds the FSM in IDLE.
  assign pop = res_n & enable & ~fifo_empty & ((state == S_IDLE) | last_stop);

  // State register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pop) state_next = S_START;
      S_START: if (bit_end) state_next = S_DATA;
      S_DATA: begin
        if (bit_end && (bit_cnt == DATA_LAST)) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      S_PARITY: if (bit_end) state_next = S_STOP;
`endif
      // A pop in the final stop cycle chains straight into the next frame.
      S_STOP:  if (last_stop) state_next = pop ? S_START : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs (tx and busy depend only on registered state, so an async reset
  // returns the line high immediately)
  always_comb begin
    fifo_shift_out = pop;
    busy           = (state != S_IDLE);
    tx             = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shift[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      S_PARITY: tx = parity_bit;
`endif
      default:  tx = 1'b1;
    endcase
  end

  // Baud counter, bit counter and shift register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (pop) begin
        shift <= fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_bit <= ^fifo_data;
`endif
      end else if ((state == S_DATA) && bit_end) begin
        shift <= shift >> 1;
      end

      if ((state == S_IDLE) || bit_end) baud <= '0;
      else                              baud <= baud + 1'b1;

      // Bit counter restarts on every state change, so it never wraps.
      if (state != state_next)
        bit_cnt <= '0;
      else if (bit_end && ((state == S_DATA) || (state == S_STOP)))
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-based FIFO model feeds the DUT, every
// pushed word is recorded as expected, and a monitor checks the serial line
// cycle by cycle against a frame built from the word.
module tb_fifo_serial_tx;

  localparam int W   = 4;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (1 + W + P + SB) * CPB;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         res_n;
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_shift_out;
  logic         tx;
  logic         busy;

  always #5 clk = ~clk;

  fifo_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk(clk), .res_n(res_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_shift_out(fifo_shift_out), .tx(tx), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pops  = 0;
  int pop_cyc[$];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] fifo_q[$];
  logic         pop_seen = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // ---------------- FIFO model (first-word-fall-through) ----------------
  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  always begin
    logic pop_now;
    @(posedge clk);
    pop_now = pop_seen;
    #1;
    if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh_fifo();
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh_fifo();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((fifo_q.size() != 0 || busy) && k < budget) begin
      tick(1);
      k++;
    end
    check(name, (k < budget), 1);
  endtask

  // ---------------- reference frame ----------------
  function automatic logic frame_bit(input logic [W-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= W) return w[b-1];
    if (P == 1 && b == W + 1) return ^w;
    return 1'b1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic         in_frame = 1'b0;
  int           fcyc = 0;
  logic [W-1:0] cur_word = '0;

  always @(negedge clk) begin
    if (res_n !== 1'b1) begin
      in_frame = 1'b0;
      check("reset_outputs", {tx, busy, fifo_shift_out}, 3'b100);
    end else begin
      if (in_frame) begin
        check("frame_tx", tx, frame_bit(cur_word, fcyc / CPB));
        check("frame_busy", busy, 1);
        fcyc++;
        if (fcyc == FRAME) in_frame = 1'b0;
      end else begin
        check("idle_line", {tx, busy}, 2'b10);
      end
      if (fifo_shift_out) begin
        check("pop_nonempty", fifo_empty, 0);
        check("pop_timing", in_frame, 0);
        n_pops++;
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pop at cycle %0d: got pop, expected none", cyc);
        end else begin
          cur_word = exp_q.pop_front();
          in_frame = 1'b1;
          fcyc     = 0;
        end
      end
    end
    pop_seen = fifo_shift_out & res_n;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    res_n  = 1'b0;
    enable = 1'b0;
    refresh_fifo();
    tick(3);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_pop", fifo_shift_out, 0);

    // Idle with empty FIFO
    res_n  = 1'b1;
    enable = 1'b1;
    tick(50);
    check("idle_no_pops", n_pops, 0);

    // Single frame
    push_word(4'b1010);
    wait_idle("drain_single", 200);
    check("single_pops", n_pops, 1);

    // Parity-visible word (frame checked by monitor in either build)
    push_word(4'b0111);
    wait_idle("drain_0111", 200);

    // Back-to-back frames
    base = pop_cyc.size();
    push_word(4'h3);
    push_word(4'hC);
    push_word(4'h5);
    wait_idle("drain_b2b", 400);
    check("b2b_pops", pop_cyc.size() - base, 3);
    if (pop_cyc.size() - base == 3) begin
      check("b2b_gap1", pop_cyc[base+1] - pop_cyc[base], FRAME);
      check("b2b_gap2", pop_cyc[base+2] - pop_cyc[base+1], FRAME);
    end

    // Enable behaviour
    enable = 1'b0;
    tick(2);
    push_word(4'hF);
    tick(30);
    check("disabled_no_pop", fifo_q.size(), 1);
    check("disabled_not_empty", fifo_empty, 0);
    enable = 1'b1;
    @(negedge clk);
    check("pop_on_enable", fifo_shift_out, 1);
    @(posedge clk);
    #1;                         // frame cycle 0
    push_word(4'h6);
    tick(8);                    // frame cycle 8
    enable = 1'b0;
    tick(FRAME + 10);
    check("held_word", fifo_q.size(), 1);
    check("held_idle", busy, 0);

    // Async reset mid-frame
    push_word(4'h9);
    enable = 1'b1;
    @(negedge clk);
    check("pop_reenable", fifo_shift_out, 1);
    @(posedge clk);
    #1;
    tick(10);                   // frame cycle 10
    #1;
    res_n = 1'b0;
    #1;
    check("async_tx", tx, 1);
    check("async_busy", busy, 0);
    check("async_pop", fifo_shift_out, 0);
    tick(3);
    #1;
    res_n = 1'b1;
    wait_idle("drain_after_reset", 200);
    check("after_reset_fifo", fifo_q.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) push_word(W'($urandom_range(0, (1 << W) - 1)));
      enable = ($urandom_range(0, 4) != 0);
      tick($urandom_range(1, 30));
    end
    enable = 1'b1;
    wait_idle("drain_random", 3000);

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_idle", {tx, busy}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
